// File: rtl/alu_accum_pkg.sv
// Shared opcodes and FSM state encoding for the sequenced accumulator ALU.
package alu_accum_pkg;
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/alu_addsub.sv
// Unsigned WIDTH-bit adder/subtractor; c is carry-out on add, borrow on subtract.
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] y,
    output logic             c
);
    logic [WIDTH:0] full;

    // The extra MSB of the (WIDTH+1)-bit difference is the borrow.
    assign full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    assign y    = full[WIDTH-1:0];
    assign c    = full[WIDTH];
endmodule

// File: rtl/alu_accum_seq.sv
// Accumulator with single-cycle LOAD/ADD/SUB and FSM-sequenced MUL/DIV,
// all arithmetic funnelled through one shared alu_addsub instance.
module alu_accum_seq
    import alu_accum_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 E,
    input  logic [2:0]           OP,
    input  logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     Q,
    output logic [CNT_WIDTH-1:0] CNT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 OVF,
    output logic                 DIVZ,
    output logic                 ZERO
);
    generate
        if (CNT_WIDTH < WIDTH) begin : g_cnt_width_check
            $error("alu_accum_seq: CNT_WIDTH must be >= WIDTH");
        end
    endgenerate

    state_t               state, state_n;
    logic [WIDTH-1:0]     q, q_n, m, m_n, r, r_n, d, d_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 ovf, ovf_n, divz, divz_n, busy, done;

    logic [WIDTH-1:0]     as_a, as_b, as_y;
    logic                 as_sub, as_c;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .y   (as_y),
        .c   (as_c)
    );

    // Operand steering kept apart from the next-state block so the adder
    // result feeds forward without a block-level loop.
    always_comb begin
        as_a   = q;
        as_b   = B;
        as_sub = (OP == OP_SUB);
        case (state)
            ST_MUL: begin as_b = m; as_sub = 1'b0; end
            ST_DIV: begin as_b = d; as_sub = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        cnt_n   = cnt;
        m_n     = m;
        r_n     = r;
        d_n     = d;
        ovf_n   = ovf;
        divz_n  = divz;
        case (state)
            ST_IDLE: begin
                if (E) begin
                    ovf_n  = 1'b0;
                    divz_n = 1'b0;
                    case (OP)
                        OP_LOAD: begin q_n = B; cnt_n = '0; end
                        OP_ADD, OP_SUB: begin q_n = as_y; ovf_n = as_c; end
                        OP_MUL: begin
                            m_n     = q;
                            r_n     = B;
                            q_n     = '0;
                            cnt_n   = '0;
                            state_n = ST_MUL;
                        end
                        OP_DIV: begin
                            d_n   = B;
                            cnt_n = '0;
                            if (B == '0) begin
                                divz_n  = 1'b1;
                                state_n = ST_FIN;
                            end else begin
                                state_n = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (r == '0) begin
                    state_n = ST_FIN;
                end else begin
                    q_n   = as_y;
                    ovf_n = ovf | as_c;
                    r_n   = r - WIDTH'(1);
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            ST_DIV: begin
                // No borrow means Q >= D, so one more subtraction fits.
                if (!as_c) begin
                    q_n   = as_y;
                    cnt_n = cnt + CNT_WIDTH'(1);
                end else begin
                    state_n = ST_FIN;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= ST_IDLE;
            q     <= '0;
            cnt   <= '0;
            m     <= '0;
            r     <= '0;
            d     <= '0;
            ovf   <= 1'b0;
            divz  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            cnt   <= cnt_n;
            m     <= m_n;
            r     <= r_n;
            d     <= d_n;
            ovf   <= ovf_n;
            divz  <= divz_n;
            busy  <= (state_n != ST_IDLE);
            done  <= (state_n == ST_FIN);
        end
    end

    assign Q    = q;
    assign CNT  = cnt;
    assign BUSY = busy;
    assign DONE = done;
    assign OVF  = ovf;
    assign DIVZ = divz;
    assign ZERO = (q == '0);
endmodule

// File: tb/tb_alu_accum_seq.sv
// Directed bench for alu_accum_seq with hand-computed expected values.
module tb_alu_accum_seq;
    import alu_accum_pkg::*;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       E   = 1'b0;
    logic [2:0] OP  = 3'd0;
    logic [7:0] B   = 8'd0;
    logic [7:0] Q;
    logic [7:0] CNT;
    logic       BUSY, DONE, OVF, DIVZ, ZERO;

    int checks   = 0;
    int failures = 0;

    alu_accum_seq #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .CLK  (CLK),
        .CLR  (CLR),
        .E    (E),
        .OP   (OP),
        .B    (B),
        .Q    (Q),
        .CNT  (CNT),
        .BUSY (BUSY),
        .DONE (DONE),
        .OVF  (OVF),
        .DIVZ (DIVZ),
        .ZERO (ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] b);
        E  = 1'b1;
        OP = op;
        B  = b;
        step();
        E  = 1'b0;
        OP = OP_NOP;
        B  = 8'd0;
    endtask

    // Issue, then count BUSY and DONE cycles until the op retires.
    task automatic run_op(input logic [2:0] op, input logic [7:0] b, input bit junk,
                          output int nbusy, output int ndone);
        nbusy = 0;
        ndone = 0;
        issue(op, b);
        if (junk) begin
            E  = 1'b1;
            OP = OP_LOAD;
            B  = 8'd0;
        end
        for (int i = 0; i < 600 && BUSY; i++) begin
            nbusy++;
            if (DONE) ndone++;
            step();
        end
        E  = 1'b0;
        OP = OP_NOP;
        if (BUSY) chk("busy_timeout", 1, 0);
    endtask

    initial begin
        int nb, nd, dseen;

        // Reset
        step(); step();
        CLR = 1'b0;
        chk("rst_q", Q, 0);
        chk("rst_cnt", CNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_divz", DIVZ, 0);
        chk("rst_zero", ZERO, 1);

        // LOAD 3, ADD 7, MUL 6, DIV 12
        issue(OP_LOAD, 8'd3);
        chk("load3_q", Q, 3);
        chk("load3_busy", BUSY, 0);
        issue(OP_ADD, 8'd7);
        chk("add7_q", Q, 10);
        run_op(OP_MUL, 8'd6, 1'b0, nb, nd);
        chk("mul6_busy", nb, 8);
        chk("mul6_done", nd, 1);
        chk("mul6_q", Q, 60);
        chk("mul6_cnt", CNT, 6);
        chk("mul6_ovf", OVF, 0);
        run_op(OP_DIV, 8'd12, 1'b0, nb, nd);
        chk("div12_q", Q, 0);
        chk("div12_cnt", CNT, 5);
        chk("div12_zero", ZERO, 1);
        chk("div12_done", nd, 1);
        chk("div12_busy", nb, 7);

        // Carry and borrow
        issue(OP_LOAD, 8'd250);
        issue(OP_ADD, 8'd10);
        chk("add_wrap_q", Q, 4);
        chk("add_wrap_ovf", OVF, 1);
        issue(OP_LOAD, 8'd3);
        chk("load_clr_ovf", OVF, 0);
        issue(OP_SUB, 8'd5);
        chk("sub_wrap_q", Q, 254);
        chk("sub_wrap_ovf", OVF, 1);
        issue(OP_NOP, 8'd9);
        chk("nop_ovf", OVF, 0);
        chk("nop_q", Q, 254);

        // Divide by zero
        issue(OP_LOAD, 8'd17);
        issue(OP_DIV, 8'd0);
        chk("divz_done_now", DONE, 1);
        chk("divz_busy_now", BUSY, 1);
        chk("divz_flag", DIVZ, 1);
        step();
        chk("divz_busy_after", BUSY, 0);
        chk("divz_done_after", DONE, 0);
        chk("divz_q", Q, 17);
        chk("divz_cnt", CNT, 0);
        issue(OP_ADD, 8'd1);
        chk("divz_clear", DIVZ, 0);
        chk("divz_add_q", Q, 18);

        // Issues while busy are ignored
        issue(OP_LOAD, 8'd100);
        run_op(OP_DIV, 8'd7, 1'b1, nb, nd);
        chk("div7_q", Q, 2);
        chk("div7_cnt", CNT, 14);
        chk("div7_busy", nb, 16);
        chk("div7_done", nd, 1);

        // CLR mid-DIV
        issue(OP_LOAD, 8'd200);
        issue(OP_DIV, 8'd1);
        dseen = 0;
        for (int i = 1; i < 5; i++) begin
            if (DONE) dseen++;
            step();
        end
        chk("clr_mid_busy", BUSY, 1);
        chk("clr_mid_q", Q, 196);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("clr_q", Q, 0);
        chk("clr_cnt", CNT, 0);
        chk("clr_busy", BUSY, 0);
        for (int i = 0; i < 5; i++) begin
            if (DONE) dseen++;
            step();
        end
        chk("clr_no_done", dseen, 0);

        // MUL by zero, then an overflowing MUL
        issue(OP_LOAD, 8'd20);
        run_op(OP_MUL, 8'd0, 1'b0, nb, nd);
        chk("mul0_q", Q, 0);
        chk("mul0_cnt", CNT, 0);
        chk("mul0_busy", nb, 2);
        issue(OP_LOAD, 8'd16);
        run_op(OP_MUL, 8'd20, 1'b0, nb, nd);
        chk("mul20_q", Q, 64);
        chk("mul20_ovf", OVF, 1);
        chk("mul20_cnt", CNT, 20);
        chk("mul20_busy", nb, 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_accum_seq.md
Name: alu_accum_seq

Overview:
- Parametrised successor to the team's 8-bit add/subtract accumulator.
- Holds a WIDTH-bit accumulator Q and executes single-cycle LOAD/ADD/SUB, plus multi-cycle MUL (repeated add) and DIV (repeated subtract) sequenced by an internal FSM.
- An iteration counter CNT replaces the testbench-side quotient loop.
- Sits between an operand source/controller and downstream logic; issue uses an enable/busy/done handshake.

Parameters:
- WIDTH, 8: accumulator and operand width.
- CNT_WIDTH, 8: iteration-counter width; must be >= WIDTH (elaboration-time check).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset, synchronous, active-high; clears all state and aborts any operation.
- E  in  1  issue strobe; sampled only in IDLE.
- OP  in  3  opcode: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6-7 NOP.
- B  in  WIDTH  operand; captured on the issue edge.
- Q  out  WIDTH  accumulator / product / remainder.
- CNT  out  CNT_WIDTH  iterations performed (quotient for DIV, multiplier for MUL).
- BUSY  out  1  high in MUL, DIV, FIN.
- DONE  out  1  one-cycle pulse in FIN.
- OVF  out  1  carry/borrow flag; sticky within an op, cleared on the next issue.
- DIVZ  out  1  divide by zero; cleared on the next issue.
- ZERO  out  1  combinational (Q == 0).

Behaviour:
- Reset (CLR=1 at an edge): Q=0, CNT=0, OVF=0, DIVZ=0, DONE=0, BUSY=0, state=IDLE. CLR has priority over everything, including mid-MUL/DIV.
- Issue: E=1 in IDLE, sampled at an edge. OVF and DIVZ clear on that edge unless the op sets them. In other states E and OP are ignored, with no queuing.
- NOP: no state change; flags clear.
- LOAD: Q<=B, CNT<=0. One cycle; no DONE, no BUSY.
- ADD: Q<=Q+B mod 2^WIDTH; OVF<=carry-out.
- SUB: Q<=Q-B mod 2^WIDTH; OVF<=borrow (B > Q unsigned).
- MUL issue edge: M<=Q, R<=B (remaining), Q<=0, CNT<=0, go to MUL.
- MUL state, each cycle:
  - R==0: go to FIN.
  - Otherwise: Q<=Q+M (wrap), OVF|=carry, R<=R-1, CNT<=CNT+1.
  - Total BUSY cycles = B+2 (B adds, one exit check, FIN).
- DIV issue edge: D<=B, CNT<=0.
  - If B==0: DIVZ<=1, go directly to FIN; Q and CNT unchanged.
  - Otherwise go to DIV.
- DIV state, each cycle:
  - Q>=D: Q<=Q-D, CNT<=CNT+1.
  - Otherwise: go to FIN.
  - Result: CNT = floor(Q0/B), Q = Q0 mod B.
- FIN: DONE=1 and BUSY=1 for exactly one cycle, then IDLE. An issue can be accepted on the first IDLE cycle, with no dead cycles beyond FIN.
- Arithmetic is unsigned throughout.
- Iteration bounds: CNT never wraps, since MUL/DIV iterations <= 2^WIDTH-1 <= 2^CNT_WIDTH-1.
- Outputs are registered except ZERO.
- Q is visible one cycle after the edge that updates it.

Decomposition:
- Shared package alu_accum_pkg:
  - opcode constants OP_NOP..OP_DIV;
  - FSM state encodings ST_IDLE, ST_MUL, ST_DIV, ST_FIN.
- One natural sub-module: alu_addsub (WIDTH-bit add/subtract returning result and carry/borrow). It is shared by ADD, SUB, MUL and DIV so that a single adder is inferred.

Test Plan:
- CLR; LOAD 3; ADD 7; MUL B=6 -> BUSY 8 cycles, DONE pulse, Q=60, CNT=6, OVF=0. Then DIV B=12 -> Q=0, CNT=5, ZERO=1, DONE once.
- LOAD 250, ADD 10 -> Q=4, OVF=1. Then LOAD 3, SUB 5 -> Q=254, OVF=1. Then NOP -> OVF=0.
- LOAD 17, DIV B=0 -> DIVZ=1, DONE on the 2nd cycle after issue, Q=17, CNT=0. Next ADD 1 -> DIVZ=0, Q=18.
- LOAD 100, DIV B=7. While BUSY, drive E=1 with OP=LOAD B=0 each cycle -> ignored. Final Q=2, CNT=14.
- LOAD 200, DIV B=1; assert CLR on the 5th busy cycle -> next cycle Q=0, CNT=0, BUSY=0, DONE never pulses.
- LOAD 20, MUL B=0 -> Q=0, CNT=0, BUSY 2 cycles. Then LOAD 16, MUL B=20 -> Q=64 (320 mod 256), OVF=1, CNT=20.
